// File: rtl/mant_div_seq.sv
// mant_div_seq: sequential restoring divider for normalized mantissas.
// Produces one quotient bit per cycle, MSB first. The quotient is
// floor(A*2^(W+1)/B) over W+2 bits, and a sticky bit flags a non-zero
// final remainder. A zero divisor skips the iteration and returns
// all-ones with dbz set.
// Optional build macro: MANT_DIV_EARLY_TERM_EN. When it is defined, the
// divider stops as soon as the partial remainder becomes zero and
// zero-fills the remaining quotient bits.
module mant_div_seq #(
  parameter int W = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   dividend,
  input  logic [W-1:0]   divisor,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [W+1:0]   quotient,
  output logic           sticky,
  output logic           dbz
);

  localparam int QW = W + 2;
  localparam int CW = $clog2(W + 3);
  localparam logic [CW-1:0] LAST_CNT = CW'(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [QW-1:0]   r_r;
  logic [W-1:0]    b_r;
  logic [CW-1:0]   count_r;
  logic [QW-1:0]   quotient_r;
  logic            sticky_r;
  logic            dbz_r;
  logic            ready_r;
  logic            busy_r;
  logic            done_r;

  logic [QW:0]     sub_s;
  logic            q_bit_s;
  logic [QW-1:0]   r_iter_s;
  logic [QW-1:0]   quot_iter_s;
  logic            last_iter_s;
  logic            early_zero_s;
  logic            finish_s;
  logic [QW-1:0]   quot_final_s;
  logic            accept_s;
  logic            div_zero_s;

  // Bit-serial ripple subtract with no carry-in: returns {borrow, a-b}.
  function automatic logic [QW:0] ripple_sub(input logic [QW-1:0] a,
                                             input logic [QW-1:0] b);
    logic [QW-1:0] diff;
    logic          brw;
    brw = 1'b0;
    for (int i = 0; i < QW; i++) begin
      diff[i] = a[i] ^ b[i] ^ brw;
      brw     = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw);
    end
    return {brw, diff};
  endfunction

  assign accept_s   = start && (state_r == IDLE);
  assign div_zero_s = (divisor == {W{1'b0}});

  // One restoring step: trial subtract, keep or restore, then shift left.
  always_comb begin
    sub_s       = ripple_sub(r_r, {2'b00, b_r});
    q_bit_s     = ~sub_s[QW];
    r_iter_s    = {QW{1'b0}};
    if (q_bit_s) begin
      r_iter_s = {sub_s[QW-2:0], 1'b0};
    end else begin
      r_iter_s = {r_r[QW-2:0], 1'b0};
    end
    quot_iter_s = {quotient_r[W:0], q_bit_s};
    last_iter_s = (count_r == LAST_CNT);
  end

`ifdef MANT_DIV_EARLY_TERM_EN
  assign early_zero_s = (r_iter_s == {QW{1'b0}});
`else
  assign early_zero_s = 1'b0;
`endif

  assign finish_s = last_iter_s || early_zero_s;

  // Final quotient: on early exit the unprocessed low bits are zero.
  always_comb begin
    quot_final_s = quot_iter_s;
    if (early_zero_s) begin
      quot_final_s = quot_iter_s << (LAST_CNT - count_r);
    end else begin
      quot_final_s = quot_iter_s;
    end
  end

  // Next-state logic for the IDLE/CALC/DONE controller.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (div_zero_s) begin
            state_s = DONE;
          end else begin
            state_s = CALC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (finish_s) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Status flags, registered from the next state so they track state_r exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      ready_r <= (state_s == IDLE);
      busy_r  <= (state_s == CALC);
      done_r  <= (state_s == DONE);
    end
  end

  // Datapath: capture operands on accept, iterate in CALC, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_r        <= {QW{1'b0}};
      b_r        <= {W{1'b0}};
      count_r    <= {CW{1'b0}};
      quotient_r <= {QW{1'b0}};
      sticky_r   <= 1'b0;
      dbz_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            b_r      <= divisor;
            r_r      <= {2'b00, dividend};
            count_r  <= {CW{1'b0}};
            sticky_r <= 1'b0;
            if (div_zero_s) begin
              quotient_r <= {QW{1'b1}};
              dbz_r      <= 1'b1;
            end else begin
              quotient_r <= {QW{1'b0}};
              dbz_r      <= 1'b0;
            end
          end
        end
        CALC: begin
          r_r     <= r_iter_s;
          count_r <= count_r + CW'(1);
          if (finish_s) begin
            quotient_r <= quot_final_s;
            sticky_r   <= (r_iter_s != {QW{1'b0}});
          end else begin
            quotient_r <= quot_iter_s;
          end
        end
        DONE: begin
          quotient_r <= quotient_r;
        end
        default: begin
          quotient_r <= quotient_r;
        end
      endcase
    end
  end

  assign ready    = ready_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign quotient = quotient_r;
  assign sticky   = sticky_r;
  assign dbz      = dbz_r;

endmodule
